// File: rtl/darksocv_wb_bridge_if.sv
// Wishbone classic bus between the Caravel management core (master)
// and the darksocv bridge (slave).
interface darksocv_wb_bridge_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/darksocv_wb_bridge.sv
// Wishbone classic slave that forwards hits in the user-area window to the
// darksocv external data port as a single read or write strobe, waits for
// XDACK (bounded by TIMEOUT), and returns a one-cycle Wishbone ack.
module darksocv_wb_bridge #(
  parameter logic [31:0] BASE    = 32'h3000_0000,
  parameter logic [31:0] MASK    = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] ERRWORD = 32'hDEAD_BEEF
) (
  input  logic                        XCLK,
  input  logic                        XRES,
  darksocv_wb_bridge_if.slave         wb,
  output logic [31:0]                 XADDR,
  output logic                        XRD,
  output logic                        XWR,
  output logic [3:0]                  XBE,
  output logic [31:0]                 XDATAO,
  input  logic [31:0]                 XDATAI,
  input  logic                        XDACK,
  output logic [7:0]                  ERRCNT
);

  typedef enum logic [1:0] {IDLE, MISS, BUSY, ACK} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       we_q;
  logic       holdoff;
  logic       req;
  logic       hit;

  assign req = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign hit = req & ((wb.wbs_adr_i & MASK) == BASE);

  // Transfer FSM; every output is a register updated on the state transition
  // that enters the state in which it must be visible.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      we_q          <= 1'b0;
      holdoff       <= 1'b0;
      XADDR         <= '0;
      XRD           <= 1'b0;
      XWR           <= 1'b0;
      XBE           <= '0;
      XDATAO        <= '0;
      ERRCNT        <= '0;
      wb.wbs_ack_o  <= 1'b0;
      wb.wbs_dat_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // holdoff masks the cycle right after ACK, while stb is still
          // being released by the master
          holdoff <= 1'b0;
          if (!holdoff) begin
            if (hit) begin
              XADDR    <= wb.wbs_adr_i & ~MASK;
              XDATAO   <= wb.wbs_dat_i;
              XBE      <= wb.wbs_sel_i;
              we_q     <= wb.wbs_we_i;
              wait_cnt <= '0;
              if (wb.wbs_we_i && (wb.wbs_sel_i == 4'b0000)) begin
                state        <= ACK;
                wb.wbs_ack_o <= 1'b1;
                wb.wbs_dat_o <= '0;
              end else begin
                state <= BUSY;
                XRD   <= ~wb.wbs_we_i;
                XWR   <= wb.wbs_we_i;
              end
            end else if (req) begin
              state <= MISS;
            end
          end
        end

        MISS: begin
          if (!wb.wbs_cyc_i) begin
            state <= IDLE;
          end else begin
            state        <= ACK;
            wb.wbs_ack_o <= 1'b1;
            wb.wbs_dat_o <= '0;
          end
        end

        BUSY: begin
          // abort beats completion; XDACK beats a coincident timeout
          if (!wb.wbs_cyc_i) begin
            state <= IDLE;
            XRD   <= 1'b0;
            XWR   <= 1'b0;
          end else if (XDACK) begin
            state        <= ACK;
            XRD          <= 1'b0;
            XWR          <= 1'b0;
            wb.wbs_ack_o <= 1'b1;
            wb.wbs_dat_o <= we_q ? '0 : XDATAI;
          end else if (wait_cnt == WAIT_LAST) begin
            state        <= ACK;
            XRD          <= 1'b0;
            XWR          <= 1'b0;
            wb.wbs_ack_o <= 1'b1;
            wb.wbs_dat_o <= we_q ? '0 : ERRWORD;
            if (ERRCNT != 8'hFF) begin
              ERRCNT <= ERRCNT + 8'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ACK: begin
          state        <= IDLE;
          holdoff      <= 1'b1;
          wb.wbs_ack_o <= 1'b0;
          wb.wbs_dat_o <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_darksocv_wb_bridge.sv
// Directed bench for darksocv_wb_bridge: stimulus pushes the expected ack
// response into a scoreboard queue; a negedge monitor pops and compares
// whenever the bridge acks.
module tb_darksocv_wb_bridge;

  typedef struct {
    logic [31:0] dat;
    int          lat;
    int          rd;
    int          wr;
    logic [7:0]  err;
    logic [31:0] xaddr;
    logic [3:0]  xbe;
    logic [31:0] xdo;
    int          start;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] xaddr;
  logic        xrd;
  logic        xwr;
  logic [3:0]  xbe;
  logic [31:0] xdatao;
  logic [31:0] xdatai;
  logic        xdack;
  logic [7:0]  errcnt;

  darksocv_wb_bridge_if wb ();

  darksocv_wb_bridge #(
    .BASE    (32'h3000_0000),
    .MASK    (32'hFFFF_0000),
    .TIMEOUT (16),
    .ERRWORD (32'hDEAD_BEEF)
  ) dut (
    .XCLK   (clk),
    .XRES   (rst_n),
    .wb     (wb),
    .XADDR  (xaddr),
    .XRD    (xrd),
    .XWR    (xwr),
    .XBE    (xbe),
    .XDATAO (xdatao),
    .XDATAI (xdatai),
    .XDACK  (xdack),
    .ERRCNT (errcnt)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   ack_delay = 0;
  int   scnt = 0;
  logic prev_ack = 1'b0;
  logic [7:0] exp_err = 8'd0;
  exp_t sbq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // SoC responder: raise XDACK in strobe cycle number ack_delay (0 = never)
  always begin
    @(posedge clk);
    #1;
    if (xrd || xwr) begin
      scnt++;
      xdack = (scnt == ack_delay);
    end else begin
      scnt  = 0;
      xdack = 1'b0;
    end
  end

  // Monitor: count strobe cycles, pop and compare on every ack
  always @(negedge clk) begin
    exp_t e;
    if (xrd) rd_cnt++;
    if (xwr) wr_cnt++;
    if (wb.wbs_ack_o) begin
      chk("ack_pulse_width", 32'(prev_ack), 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        chk("ack_dat_o", wb.wbs_dat_o, e.dat);
        chk("ack_latency", 32'(cyc - e.start), 32'(e.lat));
        chk("xrd_cycles", 32'(rd_cnt), 32'(e.rd));
        chk("xwr_cycles", 32'(wr_cnt), 32'(e.wr));
        chk("errcnt", 32'(errcnt), 32'(e.err));
        chk("xaddr", xaddr, e.xaddr);
        chk("xbe", 32'(xbe), 32'(e.xbe));
        chk("xdatao", xdatao, e.xdo);
      end
    end else if (rst_n) begin
      chk("dat_o_idle", wb.wbs_dat_o, 32'd0);
    end
    prev_ack = wb.wbs_ack_o;
  end

  task automatic drive_req(input logic [31:0] adr, input logic we,
                           input logic [3:0] sel, input logic [31:0] dat);
    wb.wbs_adr_i = adr;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_dat_i = dat;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
  endtask

  task automatic release_bus();
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  // One complete transfer with its expected response queued up front
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                      input logic [31:0] dat, input exp_t e_in);
    exp_t e;
    logic got;
    e = e_in;
    @(posedge clk);
    #1;
    rd_cnt  = 0;
    wr_cnt  = 0;
    e.start = cyc;
    sbq.push_back(e);
    drive_req(adr, we, sel, dat);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (wb.wbs_ack_o) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (!got && sbq.size() > 0) void'(sbq.pop_back());
    @(posedge clk);
    #1;
    release_bus();
  endtask

  function automatic exp_t mk(input logic [31:0] dat, input int lat, input int rd,
                              input int wr, input logic [7:0] err, input logic [31:0] xa,
                              input logic [3:0] be, input logic [31:0] xdo);
    exp_t e;
    e.dat = dat; e.lat = lat; e.rd = rd; e.wr = wr; e.err = err;
    e.xaddr = xa; e.xbe = be; e.xdo = xdo; e.start = 0;
    return e;
  endfunction

  initial begin
    rst_n  = 1'b0;
    xdatai = '0;
    xdack  = 1'b0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
    wb.wbs_sel_i = '0;
    release_bus();

    #12;
    chk("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    chk("rst_dat_o", wb.wbs_dat_o, 32'd0);
    chk("rst_xrd", 32'(xrd), 32'd0);
    chk("rst_xwr", 32'(xwr), 32'd0);
    chk("rst_xaddr", xaddr, 32'd0);
    chk("rst_xbe", 32'(xbe), 32'd0);
    chk("rst_xdatao", xdatao, 32'd0);
    chk("rst_errcnt", 32'(errcnt), 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // read hit, XDACK in first strobe cycle
    ack_delay = 1;
    xdatai = 32'h1234_5678;
    xfer(32'h3000_0010, 1'b0, 4'hF, 32'h0,
         mk(32'h1234_5678, 2, 1, 0, 8'd0, 32'h10, 4'hF, 32'h0));

    // write hit, XDACK on third strobe cycle
    ack_delay = 3;
    xfer(32'h3000_0104, 1'b1, 4'b0011, 32'hCAFE_F00D,
         mk(32'h0, 4, 0, 3, 8'd0, 32'h104, 4'b0011, 32'hCAFE_F00D));

    // miss: no strobe, latched SoC-side fields hold
    ack_delay = 1;
    xfer(32'h2000_0000, 1'b0, 4'hF, 32'h5555_5555,
         mk(32'h0, 2, 0, 0, 8'd0, 32'h104, 4'b0011, 32'hCAFE_F00D));

    // write hit with no byte selects: straight to ack
    xfer(32'h3000_0020, 1'b1, 4'b0000, 32'h1111_1111,
         mk(32'h0, 1, 0, 0, 8'd0, 32'h20, 4'b0000, 32'h1111_1111));

    // XDACK arrives in the final wait cycle: data wins, no error counted
    ack_delay = 16;
    xdatai = 32'hA5A5_5A5A;
    xfer(32'h3000_0030, 1'b0, 4'hF, 32'h0,
         mk(32'hA5A5_5A5A, 17, 16, 0, 8'd0, 32'h30, 4'hF, 32'h0));

    // abort after strobe cycles: strobe drops, no ack, ERRCNT unchanged
    ack_delay = 0;
    @(posedge clk);
    #1;
    rd_cnt = 0;
    drive_req(32'h3000_0044, 1'b0, 4'hF, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    release_bus();
    @(negedge clk);
    chk("abort_xrd_last", 32'(xrd), 32'd1);
    @(negedge clk);
    chk("abort_xrd_drop", 32'(xrd), 32'd0);
    chk("abort_no_ack", 32'(wb.wbs_ack_o), 32'd0);
    chk("abort_errcnt", 32'(errcnt), 32'(exp_err));
    repeat (3) @(posedge clk);

    ack_delay = 1;
    xdatai = 32'h0BAD_F00D;
    xfer(32'h3000_0048, 1'b0, 4'hF, 32'h0,
         mk(32'h0BAD_F00D, 2, 1, 0, 8'd0, 32'h48, 4'hF, 32'h0));

    // timeout: 16 strobe cycles, error word, ERRCNT counts
    ack_delay = 0;
    exp_err = 8'd1;
    xfer(32'h3000_0050, 1'b0, 4'hF, 32'h0,
         mk(32'hDEAD_BEEF, 17, 16, 0, 8'd1, 32'h50, 4'hF, 32'h0));

    // async reset in the middle of a write strobe
    @(posedge clk);
    #1;
    drive_req(32'h3000_0060, 1'b1, 4'hF, 32'h7777_7777);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_reset_xwr", 32'(xwr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_xwr", 32'(xwr), 32'd0);
    chk("reset_ack", 32'(wb.wbs_ack_o), 32'd0);
    chk("reset_errcnt", 32'(errcnt), 32'd0);
    release_bus();
    exp_err = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    ack_delay = 1;
    xdatai = 32'h0000_00C3;
    xfer(32'h3000_0080, 1'b0, 4'hF, 32'h0,
         mk(32'h0000_00C3, 2, 1, 0, 8'd0, 32'h80, 4'hF, 32'h0));

    // 300 timeouts: ERRCNT saturates at 255
    ack_delay = 0;
    for (int i = 0; i < 300; i++) begin
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      xfer(32'h3000_0090, 1'b0, 4'hF, 32'h0,
           mk(32'hDEAD_BEEF, 17, 16, 0, exp_err, 32'h90, 4'hF, 32'h0));
    end
    chk("errcnt_saturated", 32'(errcnt), 32'd255);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
